// File: rtl/my_encoder_if.sv
// Bundle of the upstream (operation) and downstream (IR word) handshakes of my_encoder.
// slave is the encoder side; master is the sequencer/decoder side.
interface my_encoder_if #(
    parameter int unsigned AW = 2
) ();
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic          ir_valid;
    logic          ir_ready;
    logic [15:0]   ir;
    logic [AW:0]   level;
    logic          err_illegal;

    modport master (
        output in_valid,
        output op,
        output ra,
        output rb,
        output ir_ready,
        input  in_ready,
        input  ir_valid,
        input  ir,
        input  level,
        input  err_illegal
    );

    modport slave (
        input  in_valid,
        input  op,
        input  ra,
        input  rb,
        input  ir_ready,
        output in_ready,
        output ir_valid,
        output ir,
        output level,
        output err_illegal
    );
endinterface

// File: rtl/my_encoder.sv
// Assembles 16-bit IR words from op/ra/rb and buffers them in a DEPTH-entry FIFO.
// Optional saturating illegal-op counter enabled by MY_ENCODER_ILLEGAL_CNT_EN.
module my_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    my_encoder_if.slave bus
`ifdef MY_ENCODER_ILLEGAL_CNT_EN
    ,
    output logic [7:0]  illegal_cnt
`endif
);

    typedef enum logic [2:0] {
        OpAdd     = 3'd0,
        OpAddi    = 3'd1,
        OpSub     = 3'd2,
        OpAnd     = 3'd3,
        OpOr      = 3'd4,
        OpXor     = 3'd5,
        OpNot     = 3'd6,
        OpIllegal = 3'd7
    } op_e;

    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    function automatic logic [3:0] func_code(input op_e op);
        logic [3:0] code;
        code = 4'b0000;
        unique case (op)
            OpAdd:     code = 4'b1010;
            OpAddi:    code = 4'b1001;
            OpSub:     code = 4'b1100;
            OpAnd:     code = 4'b1110;
            OpOr:      code = 4'b0010;
            OpXor:     code = 4'b0110;
            OpNot:     code = 4'b1011;
            OpIllegal: code = 4'b0000;
            default:   code = 4'b0000;
        endcase
        return code;
    endfunction

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          err_q, err_d;

    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          illegal_op;
    logic [15:0]   enc_word;
    op_e           op_in;

    assign op_in    = op_e'(bus.op);
    assign full     = (level_q == FullLevel);
    assign empty    = (level_q == '0);
    assign enc_word = {4'b0000, bus.ra, func_code(op_in), bus.rb};

    // Outputs depend only on registered state; no input-to-ir bypass.
    assign bus.in_ready    = !full;
    assign bus.ir_valid    = !empty;
    assign bus.ir          = empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign bus.level       = level_q;
    assign bus.err_illegal = err_q;

    // A reset cycle completes no handshake.
    assign accept     = bus.in_valid && !full && !rst;
    assign push       = accept && (op_in != OpIllegal);
    assign illegal_op = accept && (op_in == OpIllegal);
    assign pop        = !empty && bus.ir_ready && !rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        err_d    = illegal_op;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: ir is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

`ifdef MY_ENCODER_ILLEGAL_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (illegal_op && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt = cnt_q;
`else
`endif

endmodule

// File: tb/tb_my_encoder.sv
// Scoreboard bench for my_encoder: driver queues hand-computed IR words, a negedge
// monitor checks outputs against a small occupancy model and pops matched words.
module tb_my_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    my_encoder_if #(.AW(2)) bus ();

`ifdef MY_ENCODER_ILLEGAL_CNT_EN
    logic [7:0] illegal_cnt;
    my_encoder #(.DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .illegal_cnt (illegal_cnt)
    );
`else
    my_encoder #(.DEPTH(4), .AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    int          model_level = 0;
    logic        err_pend = 1'b0;
    int          model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: compare against the model, then advance it by this cycle's handshakes.
    always @(negedge clk) begin
        logic acc, psh, pp;
        check("in_ready", 32'(bus.in_ready), 32'(model_level != 4));
        check("ir_valid", 32'(bus.ir_valid), 32'(model_level != 0));
        check("level", 32'(bus.level), 32'(model_level));
        check("err_illegal", 32'(bus.err_illegal), 32'(err_pend));
`ifdef MY_ENCODER_ILLEGAL_CNT_EN
        check("illegal_cnt", 32'(illegal_cnt), 32'(model_cnt));
`endif
        if (model_level == 0) begin
            check("ir_when_empty", 32'(bus.ir), 32'h0);
        end else if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ir_unexpected: got 0x%0h, want no word at %0t", bus.ir, $time);
        end else begin
            check("ir_word", 32'(bus.ir), 32'(exp_q[0]));
        end
        if (rst) begin
            model_level = 0;
            err_pend    = 1'b0;
            model_cnt   = 0;
            exp_q.delete();
        end else begin
            acc = bus.in_valid && (model_level != 4);
            psh = acc && (bus.op != 3'd7);
            pp  = (model_level != 0) && bus.ir_ready;
            if (pp && exp_q.size() > 0) void'(exp_q.pop_front());
            model_level = model_level + int'(psh) - int'(pp);
            err_pend = acc && (bus.op == 3'd7);
            if (err_pend && model_cnt < 255) model_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the operation until accepted; expected word enters the scoreboard at acceptance.
    task automatic send(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [15:0] exp_ir);
        int waited;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.ra       = ra;
        bus.rb       = rb;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (op != 3'd7) exp_q.push_back(exp_ir);
                break;
            end
            waited++;
            if (waited > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: got no in_ready in 50 cycles, want accept of 0x%0h",
                         exp_ir);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    logic [15:0] legal_exp [7] = '{16'h01A2, 16'h0192, 16'h01C2, 16'h01E2,
                                   16'h0122, 16'h0162, 16'h01B2};
    logic [15:0] fill_exp  [4] = '{16'h00CF, 16'h01CE, 16'h02CD, 16'h03CC};
    logic [15:0] not_exp   [10] = '{16'h00B0, 16'h01B1, 16'h02B2, 16'h03B3, 16'h04B4,
                                    16'h05B5, 16'h06B6, 16'h07B7, 16'h08B8, 16'h09B9};

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100000");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.op       = 3'd0;
        bus.ra       = 4'h0;
        bus.rb       = 4'h0;
        bus.ir_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single ADD held in the FIFO.
        send(3'd0, 4'h3, 4'h5, 16'h03A5);
        idle(2);
        bus.ir_ready = 1'b1;
        idle(2);

        // All legal ops with downstream always ready.
        for (int i = 0; i < 7; i++) begin
            send(3'(i), 4'h1, 4'h2, legal_exp[i]);
        end
        idle(3);

        // Fill to full, stall a fifth push, then release across the pointer wrap.
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(3'd2, 4'(i), 4'(15 - i), fill_exp[i]);
        end
        fork
            send(3'd4, 4'h9, 4'h9, 16'h0929);
            begin
                idle(3);
                bus.ir_ready = 1'b1;
            end
        join
        send(3'd5, 4'hA, 4'h3, 16'h0A63);
        idle(8);

        // Illegal op: handshake only, one-cycle error pulse.
        send(3'd7, 4'hF, 4'hF, 16'h0000);
        idle(3);

        // Two words buffered, then push and pop every cycle.
        bus.ir_ready = 1'b0;
        send(3'd6, 4'h0, 4'h0, not_exp[0]);
        send(3'd6, 4'h1, 4'h1, not_exp[1]);
        bus.ir_ready = 1'b1;
        for (int i = 2; i < 10; i++) begin
            send(3'd6, 4'(i), 4'(i), not_exp[i]);
        end
        idle(4);

        // Reset with three words buffered, then a fresh push.
        bus.ir_ready = 1'b0;
        send(3'd3, 4'h7, 4'h8, 16'h07E8);
        send(3'd3, 4'h8, 4'h7, 16'h08E7);
        send(3'd3, 4'hF, 4'h0, 16'h0FE0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        send(3'd1, 4'hC, 4'hD, 16'h0C9D);
        idle(1);
        bus.ir_ready = 1'b1;
        idle(3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
